// File: rtl/reg_wb_scheduler_pkg.sv
// Shared sizing defaults and the write-back entry type for the register-file
// write-back scheduler.
package reg_wb_scheduler_pkg;
    localparam int DEPTH_DEF  = 4;
    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 8;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/reg_wb_scheduler_wb_queue.sv
// In-order pending-write FIFO: two ordered pushes (slot 0 older), one pop,
// occupancy count and per-entry address match for read-hazard detection.
module wb_queue
    import reg_wb_scheduler_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_push0,
    input  logic [ADDR_W-1:0]           i_addr0,
    input  logic [DATA_W-1:0]           i_data0,
    input  logic                        i_push1,
    input  logic [ADDR_W-1:0]           i_addr1,
    input  logic [DATA_W-1:0]           i_data1,
    input  logic                        i_pop,
    input  logic [ADDR_W-1:0]           i_rd1_addr,
    input  logic [ADDR_W-1:0]           i_rd2_addr,
    output logic [ADDR_W-1:0]           o_head_addr,
    output logic [DATA_W-1:0]           o_head_data,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic [DEPTH-1:0]            o_match1,
    output logic [DEPTH-1:0]            o_match2
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     w_slot1;
    logic [DEPTH-1:0]  w_valid;

    // The second push lands behind the first when both are present.
    assign w_slot1 = r_wr_ptr + PW'(i_push0);

    always_ff @(posedge i_clk) begin
        if (i_push0) begin
            r_addr[r_wr_ptr] <= i_addr0;
            r_data[r_wr_ptr] <= i_data0;
        end
        if (i_push1) begin
            r_addr[w_slot1] <= i_addr1;
            r_data[w_slot1] <= i_data1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(i_push0) + PW'(i_push1);
            r_rd_ptr <= r_rd_ptr + PW'(i_pop);
            r_count  <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(i_pop);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] w_off;
        // Distance from head, modulo DEPTH; entry is live if within count.
        assign w_off       = PW'(i) - r_rd_ptr;
        assign w_valid[i]  = CW'(w_off) < r_count;
        assign o_match1[i] = w_valid[i] && (r_addr[i] == i_rd1_addr);
        assign o_match2[i] = w_valid[i] && (r_addr[i] == i_rd2_addr);
    end

    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];
    assign o_count     = r_count;
endmodule

// File: rtl/reg_wb_scheduler.sv
// Register-file write-back scheduler: merges ALU and load-return writes onto
// the single write port in arrival order and flags pending-write read hazards.
module reg_wb_scheduler
    import reg_wb_scheduler_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              ALU_WRITE,
    input  logic [ADDR_W-1:0] ALU_ADDR,
    input  logic [DATA_W-1:0] ALU_DATA,
    input  logic              MEM_WRITE,
    input  logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_DATA,
    input  logic [ADDR_W-1:0] RD1_ADDR,
    input  logic [ADDR_W-1:0] RD2_ADDR,
    output logic              WRITE,
    output logic [ADDR_W-1:0] INADDRESS,
    output logic [DATA_W-1:0] IN,
    output logic              STALL,
    output logic              HAZARD1,
    output logic              HAZARD2,
    output logic              OVERFLOW
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              r_write;
    logic [ADDR_W-1:0] r_inaddr;
    logic [DATA_W-1:0] r_in;
    logic              r_ovf;

    logic [CW-1:0]     w_count, w_space;
    logic              w_empty, w_pop;
    logic              w_want0, w_want1, w_acc0, w_acc1, w_drop;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [DEPTH-1:0]  w_match1, w_match2;

    assign w_empty = (w_count == '0);
    assign w_pop   = !w_empty;
    assign w_space = CW'(DEPTH) - w_count;

    // A non-empty queue owns the output stage, so every request queues;
    // otherwise MEM (older) bypasses and only a same-cycle ALU queues.
    assign w_want0 = MEM_WRITE && !w_empty;
    assign w_want1 = ALU_WRITE && (!w_empty || MEM_WRITE);
    assign w_acc0  = w_want0 && (w_space != '0);
    assign w_acc1  = w_want1 && (w_space > CW'(w_acc0));
    assign w_drop  = (w_want0 && !w_acc0) || (w_want1 && !w_acc1);

    wb_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_queue (
        .i_clk       (CLOCK),
        .i_rst_n     (RESET),
        .i_push0     (w_acc0),
        .i_addr0     (MEM_ADDR),
        .i_data0     (MEM_DATA),
        .i_push1     (w_acc1),
        .i_addr1     (ALU_ADDR),
        .i_data1     (ALU_DATA),
        .i_pop       (w_pop),
        .i_rd1_addr  (RD1_ADDR),
        .i_rd2_addr  (RD2_ADDR),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_count     (w_count),
        .o_match1    (w_match1),
        .o_match2    (w_match2)
    );

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_write  <= 1'b0;
            r_inaddr <= '0;
            r_in     <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_ovf   <= r_ovf | w_drop;
            r_write <= w_pop | MEM_WRITE | ALU_WRITE;
            if (w_pop) begin
                r_inaddr <= w_head_addr;
                r_in     <= w_head_data;
            end else if (MEM_WRITE) begin
                r_inaddr <= MEM_ADDR;
                r_in     <= MEM_DATA;
            end else if (ALU_WRITE) begin
                r_inaddr <= ALU_ADDR;
                r_in     <= ALU_DATA;
            end
        end
    end

    assign WRITE     = r_write;
    assign INADDRESS = r_inaddr;
    assign IN        = r_in;
    assign OVERFLOW  = r_ovf;
    assign STALL     = (w_count >= CW'(DEPTH - 1));
    assign HAZARD1   = (r_write && (r_inaddr == RD1_ADDR)) || (|w_match1);
    assign HAZARD2   = (r_write && (r_inaddr == RD2_ADDR)) || (|w_match2);
endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Bench for reg_wb_scheduler: directed vector table, corner-case sequences and
// random traffic, all checked against a queue-level model of the write order.
module tb_reg_wb_scheduler;
    import reg_wb_scheduler_pkg::*;

    localparam int DEPTH = 4;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic       ALU_WRITE = 1'b0, MEM_WRITE = 1'b0;
    logic [2:0] ALU_ADDR = '0, MEM_ADDR = '0, RD1_ADDR = '0, RD2_ADDR = '0;
    logic [7:0] ALU_DATA = '0, MEM_DATA = '0;
    logic       WRITE, STALL, HAZARD1, HAZARD2, OVERFLOW;
    logic [2:0] INADDRESS;
    logic [7:0] IN;

    reg_wb_scheduler #(.DEPTH(DEPTH), .ADDR_W(3), .DATA_W(8)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .ALU_WRITE(ALU_WRITE), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA),
        .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
        .RD1_ADDR(RD1_ADDR), .RD2_ADDR(RD2_ADDR),
        .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
        .STALL(STALL), .HAZARD1(HAZARD1), .HAZARD2(HAZARD2), .OVERFLOW(OVERFLOW)
    );

    always #5 CLOCK = ~CLOCK;

    // Register file image as committed by the write port.
    logic [7:0] rf [8];
    always @(posedge CLOCK) if (WRITE) rf[INADDRESS] <= IN;

    int n_chk = 0, n_pass = 0;

    // Model: output stage plus list of pending writes in arrival order.
    bit         m_known = 0, m_w = 0, m_ovf = 0;
    logic [2:0] m_a = '0;
    logic [7:0] m_d = '0;
    wb_entry_t  m_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic bit pend_hit(input logic [2:0] ra);
        bit h = m_w && (m_a == ra);
        foreach (m_q[k]) if (m_q[k].addr == ra) h = 1;
        return h;
    endfunction

    task automatic check_model();
        if (!m_known) return;
        chk("write", WRITE, m_w);
        chk("inaddress", INADDRESS, m_a);
        chk("in", IN, m_d);
        chk("stall", STALL, m_q.size() >= DEPTH - 1);
        chk("hazard1", HAZARD1, pend_hit(RD1_ADDR));
        chk("hazard2", HAZARD2, pend_hit(RD2_ADDR));
        chk("overflow", OVERFLOW, m_ovf);
    endtask

    task automatic model_tick();
        wb_entry_t inc [$];
        wb_entry_t e;
        int room;
        if (!RESET) begin
            m_w = 0; m_a = '0; m_d = '0; m_ovf = 0; m_q.delete(); m_known = 1;
            return;
        end
        if (MEM_WRITE) inc.push_back('{addr: MEM_ADDR, data: MEM_DATA});
        if (ALU_WRITE) inc.push_back('{addr: ALU_ADDR, data: ALU_DATA});
        if (m_q.size() != 0) begin
            room = DEPTH - m_q.size();
            e = m_q.pop_front();
            m_w = 1; m_a = e.addr; m_d = e.data;
            foreach (inc[k]) begin
                if (room > 0) begin m_q.push_back(inc[k]); room--; end
                else m_ovf = 1;
            end
        end else if (inc.size() != 0) begin
            e = inc.pop_front();
            m_w = 1; m_a = e.addr; m_d = e.data;
            foreach (inc[k]) m_q.push_back(inc[k]);
        end else begin
            m_w = 0;
        end
    endtask

    task automatic apply(input bit rn, input bit mw, input logic [2:0] ma, input logic [7:0] md,
                         input bit aw, input logic [2:0] aa, input logic [7:0] ad,
                         input logic [2:0] r1, input logic [2:0] r2);
        @(negedge CLOCK);
        RESET = rn; MEM_WRITE = mw; MEM_ADDR = ma; MEM_DATA = md;
        ALU_WRITE = aw; ALU_ADDR = aa; ALU_DATA = ad; RD1_ADDR = r1; RD2_ADDR = r2;
        #1;
        check_model();
    endtask

    task automatic tick();
        @(posedge CLOCK);
        model_tick();
    endtask

    task automatic idle(input bit rn, input logic [2:0] r1);
        apply(rn, 0, 0, 0, 0, 0, 0, r1, 7);
    endtask

    typedef struct {
        bit chk; bit rn;
        bit mw; logic [2:0] ma; logic [7:0] md;
        bit aw; logic [2:0] aa; logic [7:0] ad;
        logic [2:0] r1, r2;
        bit w; logic [2:0] a; logic [7:0] d; bit s, h1, h2, o;
    } vec_t;

    vec_t tbl [11];
    int   nwr, nxt;

    initial begin
        // Expected fields are the outputs seen while that row is applied.
        tbl[0]  = '{0, 0, 0,0,0,     1,3,8'h77, 0,7, 0,0,0,     0,0,0,0};
        tbl[1]  = '{1, 0, 0,0,0,     1,3,8'h77, 0,7, 0,0,0,     0,0,0,0};
        tbl[2]  = '{1, 1, 0,0,0,     0,0,0,     0,7, 0,0,0,     0,0,0,0};
        tbl[3]  = '{1, 1, 0,0,0,     0,0,0,     0,7, 0,0,0,     0,0,0,0};
        tbl[4]  = '{1, 1, 0,0,0,     1,3,8'h5A, 3,7, 0,0,0,     0,0,0,0};
        tbl[5]  = '{1, 1, 0,0,0,     0,0,0,     3,7, 1,3,8'h5A, 0,1,0,0};
        tbl[6]  = '{1, 1, 0,0,0,     0,0,0,     3,7, 0,3,8'h5A, 0,0,0,0};
        tbl[7]  = '{1, 1, 1,2,8'h11, 1,2,8'h22, 2,7, 0,3,8'h5A, 0,0,0,0};
        tbl[8]  = '{1, 1, 0,0,0,     0,0,0,     2,7, 1,2,8'h11, 0,1,0,0};
        tbl[9]  = '{1, 1, 0,0,0,     0,0,0,     2,7, 1,2,8'h22, 0,1,0,0};
        tbl[10] = '{1, 1, 0,0,0,     0,0,0,     2,7, 0,2,8'h22, 0,0,0,0};

        foreach (tbl[i]) begin
            apply(tbl[i].rn, tbl[i].mw, tbl[i].ma, tbl[i].md,
                  tbl[i].aw, tbl[i].aa, tbl[i].ad, tbl[i].r1, tbl[i].r2);
            if (tbl[i].chk) begin
                chk($sformatf("tbl%0d_write", i), WRITE, tbl[i].w);
                chk($sformatf("tbl%0d_addr", i), INADDRESS, tbl[i].a);
                chk($sformatf("tbl%0d_data", i), IN, tbl[i].d);
                chk($sformatf("tbl%0d_stall", i), STALL, tbl[i].s);
                chk($sformatf("tbl%0d_haz1", i), HAZARD1, tbl[i].h1);
                chk($sformatf("tbl%0d_haz2", i), HAZARD2, tbl[i].h2);
                chk($sformatf("tbl%0d_ovf", i), OVERFLOW, tbl[i].o);
            end
            tick();
        end
        chk("rf_r2_final", rf[2], 8'h22);

        // Fill and stall: r0..r5 as three dual requests, then drain.
        idle(0, 0); tick();
        nxt = 0;
        for (int k = 0; k < 9; k++) begin
            if (k < 3) apply(1, 1, 3'(2*k), 8'(8'hA0 + 2*k), 1, 3'(2*k+1), 8'(8'hA1 + 2*k), 0, 7);
            else       idle(1, 0);
            if (k == 3) chk("fill_stall_hi", STALL, 1);
            if (k == 4) chk("fill_stall_lo", STALL, 0);
            if (WRITE) begin
                chk("fill_order", INADDRESS, nxt[2:0]);
                nxt++;
            end
            tick();
        end
        chk("fill_count", nxt, 6);

        // Overflow: keep pushing through STALL; only accepted writes retire.
        idle(0, 0); tick();
        nwr = 0;
        for (int k = 0; k < 12; k++) begin
            if (k < 5) apply(1, 1, 3'(k), 8'(8'h80 + 2*k), 1, 3'(k+3), 8'(8'h81 + 2*k), 0, 7);
            else       idle(1, 0);
            if (WRITE) nwr++;
            tick();
        end
        chk("ovf_writes", nwr, 8);
        idle(1, 0);
        chk("ovf_sticky", OVERFLOW, 1);
        tick();
        idle(0, 0); tick();
        idle(1, 0);
        chk("ovf_cleared", OVERFLOW, 0);
        tick();

        // Hazard on queued r4, then reset with two entries pending.
        apply(1, 1, 1, 8'h31, 1, 4, 8'h34, 4, 7); tick();
        apply(1, 1, 5, 8'h35, 1, 6, 8'h36, 4, 7);
        chk("haz_queued", HAZARD1, 1);
        tick();
        idle(0, 4);
        chk("haz_outstage", HAZARD1, 1);
        tick();
        idle(1, 4);
        chk("haz_after_rst", HAZARD1, 0);
        chk("write_after_rst", WRITE, 0);
        tick();
        idle(1, 5);
        chk("lost_after_rst", WRITE, 0);
        tick();

        // Random traffic, mostly honouring STALL, with occasional resets.
        for (int k = 0; k < 400; k++) begin
            bit rn, mw, aw;
            rn = ($urandom % 60) != 0;
            mw = $urandom % 2;
            aw = $urandom % 2;
            if (m_q.size() >= DEPTH - 1 && ($urandom % 8) != 0) begin mw = 0; aw = 0; end
            apply(rn, mw, 3'($urandom), 8'($urandom), aw, 3'($urandom), 8'($urandom),
                  3'($urandom), 3'($urandom));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
